// File: rtl/omux_arbiter.sv
// Round-robin, packet-locked arbiter sharing the FT2232 host-write path between
// NREQ byte-stream requesters; every output is registered.
module omux_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [NREQ-1:0]     req_i,
    input  logic [8*NREQ-1:0]   data_i,
    output logic [NREQ-1:0]     sel_o,
    input  logic                out_rdy_i,
    output logic [7:0]          out_data_o,
    output logic                out_wr_o,
    output logic [NREQ-1:0]     grant_o,
    output logic                busy_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SEL,
        S_WR
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_last_q, rr_last_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            final_q, final_d;

    logic [NREQ-1:0] sel_d, grant_d;
    logic [7:0]      data_d;
    logic            wr_d, busy_d;

    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand;

    // Scan from the farthest candidate to the nearest so the nearest requester
    // after rr_last is the one left standing.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = IW'((int'(rr_last_q) + i) % NREQ);
            if (req_i[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned; a missing default here would infer a latch.
        state_d   = state_q;
        rr_last_d = rr_last_q;
        idx_d     = idx_q;
        final_d   = final_q;
        sel_d     = '0;
        wr_d      = 1'b0;
        data_d    = out_data_o;
        grant_d   = grant_o;
        busy_d    = busy_o;

        unique case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    idx_d   = pick_idx;
                    grant_d = NREQ'(1) << pick_idx;
                    busy_d  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (out_rdy_i) begin
                    sel_d   = grant_o;
                    state_d = S_SEL;
                end
            end
            S_SEL: begin
                // The requester advances on this edge, so this is the byte it
                // was presenting during the select cycle.
                data_d  = data_i[{idx_q, 3'b000} +: 8];
                final_d = ~req_i[idx_q];
                wr_d    = 1'b1;
                state_d = S_WR;
            end
            S_WR: begin
                if (final_q) begin
                    rr_last_d = idx_q;
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end else if (out_rdy_i) begin
                    sel_d   = grant_o;
                    state_d = S_SEL;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            rr_last_q  <= IW'(NREQ - 1);
            idx_q      <= '0;
            final_q    <= 1'b0;
            sel_o      <= '0;
            out_wr_o   <= 1'b0;
            out_data_o <= 8'h00;
            grant_o    <= '0;
            busy_o     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            idx_q      <= idx_d;
            final_q    <= final_d;
            sel_o      <= sel_d;
            out_wr_o   <= wr_d;
            out_data_o <= data_d;
            grant_o    <= grant_d;
            busy_o     <= busy_d;
        end
    end

endmodule

// File: tb/tb_omux_arbiter.sv
// Scoreboard bench for omux_arbiter: behavioural requesters feed byte packets,
// expected writes are queued at stimulus time and checked by a separate monitor.
module tb_omux_arbiter;

    localparam int NREQ = 2;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic [NREQ-1:0]   req_i;
    logic [8*NREQ-1:0] data_i;
    logic [NREQ-1:0]   sel_o;
    logic              out_rdy_i;
    logic [7:0]        out_data_o;
    logic              out_wr_o;
    logic [NREQ-1:0]   grant_o;
    logic              busy_o;

    omux_arbiter #(.NREQ(NREQ)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .req_i      (req_i),
        .data_i     (data_i),
        .sel_o      (sel_o),
        .out_rdy_i  (out_rdy_i),
        .out_data_o (out_data_o),
        .out_wr_o   (out_wr_o),
        .grant_o    (grant_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int         req;
        logic [7:0] data;
    } exp_t;

    exp_t            exp_q[$];
    logic [NREQ-1:0] gseq[$];
    logic [NREQ-1:0] last_grant = '0;
    int              vectors = 0;
    int              miscompares = 0;

    // Behavioural requesters: req stays high while more bytes follow the
    // presented one, and a byte is consumed on the edge ending its sel cycle.
    logic [7:0]      pkt_mem [NREQ][8];
    int              pkt_len [NREQ];
    int              pkt_idx [NREQ];
    bit              pkt_act [NREQ];
    logic [NREQ-1:0] sel_seen = '0;

    always_comb begin
        req_i  = '0;
        data_i = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pkt_act[k]) begin
                req_i[k]         = (pkt_idx[k] < pkt_len[k] - 1);
                data_i[8*k +: 8] = pkt_mem[k][pkt_idx[k]];
            end
        end
    end

    task automatic clear_requesters();
        for (int k = 0; k < NREQ; k++) begin
            pkt_act[k] = 1'b0;
            pkt_idx[k] = 0;
            pkt_len[k] = 0;
        end
        sel_seen = '0;
    endtask

    always @(negedge clk_i) sel_seen = sel_o;

    always @(posedge clk_i) begin
        #1;
        if (reset_i) begin
            clear_requesters();
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (sel_seen[k] && pkt_act[k]) begin
                    pkt_idx[k] = pkt_idx[k] + 1;
                    if (pkt_idx[k] >= pkt_len[k]) pkt_act[k] = 1'b0;
                end
            end
            sel_seen = '0;
        end
    end

    always @(posedge reset_i) clear_requesters();

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired before the awaited event", name);
    endtask

    task automatic start_pkt(input int k, input int n, input logic [63:0] bytes);
        for (int i = 0; i < n; i++) pkt_mem[k][i] = bytes[8*i +: 8];
        pkt_len[k] = n;
        pkt_idx[k] = 0;
        pkt_act[k] = 1'b1;
    endtask

    task automatic push_exp(input int k, input int n, input logic [63:0] bytes);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.req  = k;
            e.data = bytes[8*i +: 8];
            exp_q.push_back(e);
        end
    endtask

    // Monitor: pops one expectation per write strobe and watches bus hygiene.
    logic prev_sel = 1'b0;
    logic prev_wr  = 1'b0;

    always @(negedge clk_i) begin
        exp_t e;
        if (grant_o !== last_grant) begin
            gseq.push_back(grant_o);
            last_grant = grant_o;
        end
        if (reset_i) begin
            prev_sel = 1'b0;
            prev_wr  = 1'b0;
        end else begin
            if (out_wr_o) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: got data 0x%0h with empty scoreboard", out_data_o);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_data", 32'(out_data_o), 32'(e.data));
                    check("wr_owner", 32'(grant_o), 32'(1) << e.req);
                end
                check("wr_single_cycle", 32'(prev_wr), 32'd0);
            end
            if (sel_o != '0) begin
                check("sel_only_to_owner", 32'(sel_o & ~grant_o), 32'd0);
                check("sel_single_cycle", 32'(prev_sel), 32'd0);
            end
            prev_sel = (sel_o != '0);
            prev_wr  = out_wr_o;
        end
    end

    task automatic wait_done(input string name, input int limit);
        int n;
        n = 0;
        while ((busy_o || pkt_act[0] || pkt_act[1] || exp_q.size() != 0) && n < limit) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= limit) fail_now(name);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_i = 1'b1;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] wr_cycles;
        int          sel_cnt;
        int          n;

        reset_i   = 1'b1;
        out_rdy_i = 1'b1;
        clear_requesters();
        repeat (3) @(negedge clk_i);
        check("reset_sel", 32'(sel_o), 32'd0);
        check("reset_wr", 32'(out_wr_o), 32'd0);
        check("reset_data", 32'(out_data_o), 32'd0);
        check("reset_grant", 32'(grant_o), 32'd0);
        check("reset_busy", 32'(busy_o), 32'd0);
        reset_i = 1'b0;

        // Single register reply: writes on cycles 3,5,7,9,11 after req rises.
        @(negedge clk_i);
        push_exp(0, 5, 64'h12_34_56_78_AB);
        start_pkt(0, 5, 64'h12_34_56_78_AB);
        wr_cycles = '0;
        sel_cnt   = 0;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk_i);
            if (out_wr_o) wr_cycles[c] = 1'b1;
            if (sel_o[0]) sel_cnt++;
            if (c == 1) check("t1_grant_after_arb", 32'(grant_o), 32'h1);
            if (c == 12) begin
                check("t1_grant_released", 32'(grant_o), 32'h0);
                check("t1_busy_released", 32'(busy_o), 32'h0);
            end
        end
        check("t1_write_cycles", 32'(wr_cycles), 32'h0AA8);
        check("t1_sel_pulses", 32'(sel_cnt), 32'd5);
        wait_done("t1_done", 20);

        // Simultaneous requests from reset: requester 0 first, then 1.
        do_reset();
        @(negedge clk_i);
        gseq.delete();
        push_exp(0, 5, 64'hA4_A3_A2_A1_A0);
        push_exp(1, 3, 64'h03_02_01);
        start_pkt(0, 5, 64'hA4_A3_A2_A1_A0);
        start_pkt(1, 3, 64'h03_02_01);
        wait_done("t2_done", 60);
        check("t2_grant_steps", 32'(gseq.size()), 32'd4);
        if (gseq.size() == 4) begin
            check("t2_grant_first", 32'(gseq[0]), 32'h1);
            check("t2_grant_gap", 32'(gseq[1]), 32'h0);
            check("t2_grant_second", 32'(gseq[2]), 32'h2);
        end

        // Round robin: 0 wins with rr_last=1, then 1 beats a re-raised 0.
        gseq.delete();
        push_exp(0, 2, 64'hC1_C0);
        push_exp(1, 2, 64'hD1_D0);
        push_exp(0, 3, 64'hE2_E1_E0);
        start_pkt(0, 2, 64'hC1_C0);
        start_pkt(1, 2, 64'hD1_D0);
        n = 0;
        while (pkt_act[0] && n < 30) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 30) fail_now("t3_first_packet");
        start_pkt(0, 3, 64'hE2_E1_E0);
        wait_done("t3_done", 60);
        check("t3_grant_steps", 32'(gseq.size()), 32'd6);
        if (gseq.size() == 6) begin
            check("t3_grant_first", 32'(gseq[0]), 32'h1);
            check("t3_grant_second", 32'(gseq[2]), 32'h2);
            check("t3_grant_third", 32'(gseq[4]), 32'h1);
        end

        // Backpressure after the 2nd byte for 4 cycles.
        push_exp(0, 5, 64'hF4_F3_F2_F1_F0);
        start_pkt(0, 5, 64'hF4_F3_F2_F1_F0);
        n = 0;
        for (int c = 0; c < 30 && n < 2; c++) begin
            @(negedge clk_i);
            if (out_wr_o) n++;
        end
        if (n < 2) fail_now("t4_second_write");
        out_rdy_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            check("t4_stall_quiet", 32'({sel_o, out_wr_o}), 32'd0);
        end
        out_rdy_i = 1'b1;
        @(negedge clk_i);
        check("t4_resume_sel", 32'(sel_o), 32'h1);
        @(negedge clk_i);
        check("t4_resume_wr", 32'(out_wr_o), 32'd1);
        wait_done("t4_done", 40);

        // Reset between the 3rd and 4th byte of a requester-1 packet.
        push_exp(1, 5, 64'h95_94_93_92_91);
        start_pkt(1, 5, 64'h95_94_93_92_91);
        n = 0;
        for (int c = 0; c < 30 && n < 3; c++) begin
            @(negedge clk_i);
            if (out_wr_o) n++;
        end
        if (n < 3) fail_now("t5_third_write");
        @(negedge clk_i);
        #2;
        reset_i = 1'b1;
        #1;
        check("t5_reset_sel", 32'(sel_o), 32'd0);
        check("t5_reset_wr", 32'(out_wr_o), 32'd0);
        check("t5_reset_data", 32'(out_data_o), 32'd0);
        check("t5_reset_grant", 32'(grant_o), 32'd0);
        check("t5_reset_busy", 32'(busy_o), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        check("t5_quiet_after_reset", 32'({sel_o, out_wr_o}), 32'd0);
        push_exp(1, 3, 64'h3C_A5_5A);
        start_pkt(1, 3, 64'h3C_A5_5A);
        @(negedge clk_i);
        check("t5_fresh_grant", 32'(grant_o), 32'h2);
        wait_done("t5_done", 40);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
